uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync.sv | 28 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared UART framing constants and receiver FSM encoding
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_sync : multi-flop synchronizer for the async serial line,
//             resets to the idle (high) level.          Rev 1.0
// ------------------------------------------------------------------
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk1,
  input  logic areset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk1 or negedge areset) begin
    if (!areset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, mid-bit 2-of-3 majority sampling.
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk1,
  input  logic                 areset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int MID    = CLKS_PER_BIT / 2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(MID - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(MID);
  localparam logic [TICK_W-1:0] TICK_DEC  = TICK_W'(MID + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 sline;
  logic                 sline_prev;
  rx_state_t            state, state_nxt;
  logic [TICK_W-1:0]    tick, tick_nxt;
  logic [BIT_W-1:0]     bit_idx, bit_idx_nxt;
  logic [1:0]           samp, samp_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] rx_data_nxt;
  logic                 rx_valid_nxt;
  logic                 frame_err_nxt;
  logic                 wrap;
  logic                 decide;
  logic                 maj;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk1  (clk1),
    .areset(areset),
    .din   (rx_serial),
    .dout  (sline)
  );

  assign wrap   = (tick == TICK_LAST);
  assign decide = (tick == TICK_DEC);
  // Third vote is the live line at the decision tick.
  assign maj    = (samp[0] & samp[1]) | (samp[0] & sline) | (samp[1] & sline);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk1 or negedge areset) begin
    if (!areset) begin
      state      <= ST_IDLE;
      sline_prev <= 1'b1;
      tick       <= '0;
      bit_idx    <= '0;
      samp       <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sline_prev <= sline;
      tick       <= tick_nxt;
      bit_idx    <= bit_idx_nxt;
      samp       <= samp_nxt;
      shreg      <= shreg_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    tick_nxt      = wrap ? '0 : tick + 1'b1;
    bit_idx_nxt   = bit_idx;
    samp_nxt      = samp;
    shreg_nxt     = shreg;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;

    if (tick == TICK_S0) samp_nxt[0] = sline;
    if (tick == TICK_S1) samp_nxt[1] = sline;

    case (state)
      ST_IDLE: begin
        tick_nxt    = '0;
        bit_idx_nxt = '0;
        if (sline_prev == STOP_BIT && sline == START_BIT) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (decide && maj == STOP_BIT) begin
          state_nxt = ST_IDLE;
          tick_nxt  = '0;
        end else if (wrap) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide) begin
          shreg_nxt = {maj, shreg[DATA_BITS-1:1]};
        end
        if (wrap) begin
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) begin
            state_nxt   = ST_STOP;
            bit_idx_nxt = '0;
          end
        end
      end
      ST_STOP: begin
        if (decide) begin
          tick_nxt = '0;
          if (maj == STOP_BIT) begin
            rx_data_nxt  = shreg;
            rx_valid_nxt = 1'b1;
            state_nxt    = ST_IDLE;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must go high before a new start is armed.
        tick_nxt = '0;
        if (sline == STOP_BIT) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tick_nxt  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx : directed scoreboard bench for uart_rx (16 clks/bit).
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk1 = 1'b0;
  logic       areset = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_err = 0;
  int   busy_cycles = 0;
  int   busy_snap;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk1     (clk1),
    .areset   (areset),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx_serial = b;
    repeat (n) @(negedge clk1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
    drive(START_BIT, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    drive(stop_val, stop_len);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    q.push_back('{err: 1'b0, data: d});
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk1);
      k++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk1);
        if (busy) busy_cycles++;
        if (areset && (rx_valid || frame_err)) begin
          if (rx_valid) n_valid++;
          if (frame_err) n_err++;
          check("pulse_exclusive", 32'(rx_valid && frame_err), 32'd0);
          check("sb_nonempty", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("sb_kind", 32'(frame_err), 32'(e.err));
            check("sb_data", 32'(rx_data), 32'(e.data));
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    areset = 1'b1;
    repeat (5) @(negedge clk1);

    // Single frame 0xA5
    expect_byte(8'hA5);
    send_frame(8'hA5, STOP_BIT, CPB);
    check("a5_busy_after_stop", 32'(busy), 32'd0);
    wait_drain("a5_drain");
    check("a5_valid_count", 32'(n_valid), 32'd1);
    check("a5_err_count", 32'(n_err), 32'd0);

    // Back-to-back 0x00, 0xFF
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, STOP_BIT, CPB);
    send_frame(8'hFF, STOP_BIT, CPB);
    drive(1'b1, CPB);
    wait_drain("b2b_drain");
    check("b2b_valid_count", 32'(n_valid), 32'd3);

    // 3-cycle low glitch: false start
    busy_snap = busy_cycles;
    drive(1'b0, 3);
    drive(1'b1, 30);
    check("glitch_busy_rose", 32'(busy_cycles > busy_snap), 32'd1);
    check("glitch_busy_back", 32'(busy), 32'd0);
    check("glitch_valid_count", 32'(n_valid), 32'd3);
    check("glitch_err_count", 32'(n_err), 32'd0);

    // Stop bit held low (break), then recovery with 0x5A
    q.push_back('{err: 1'b1, data: 8'hFF});
    send_frame(8'h3C, 1'b0, 40);
    check("break_wait_idle_busy", 32'(busy), 32'd1);
    check("break_err_count", 32'(n_err), 32'd1);
    check("break_rx_data_held", 32'(rx_data), 32'hFF);
    drive(1'b1, 20);
    check("break_idle_busy", 32'(busy), 32'd0);
    check("break_no_valid", 32'(n_valid), 32'd3);
    expect_byte(8'h5A);
    send_frame(8'h5A, STOP_BIT, CPB);
    drive(1'b1, CPB);
    wait_drain("recover_drain");
    check("recover_valid_count", 32'(n_valid), 32'd4);

    // 0x81 with a 1-cycle high glitch at the middle sample of data bit 3
    expect_byte(8'h81);
    drive(START_BIT, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b0, 9);
    drive(1'b1, 1);
    drive(1'b0, 6);
    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(STOP_BIT, CPB);
    wait_drain("glitch81_drain");
    check("glitch81_rx_data", 32'(rx_data), 32'h81);

    // Reset during data bit 4, then a clean 0x7E
    drive(START_BIT, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b0, 8);
    areset = 1'b0;
    @(negedge clk1);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk1);
    areset = 1'b1;
    repeat (4) @(negedge clk1);
    expect_byte(8'h7E);
    send_frame(8'h7E, STOP_BIT, CPB);
    drive(1'b1, CPB);
    wait_drain("post_rst_drain");
    check("post_rst_rx_data", 32'(rx_data), 32'h7E);
    check("post_rst_valid_count", 32'(n_valid), 32'd6);
    check("post_rst_err_count", 32'(n_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
